// File: rtl/mult_dot_acc.sv
// mult_dot_acc: registers 8x8 unsigned operand pairs into the shared combinational
// multiplier and sums LEN products into one dot product, handed off via valid/ready.
module mult (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] Out
);
  assign Out = {8'd0, A} * {8'd0, B};
endmodule

module mult_dot_acc #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16 + $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);
  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic             p_valid_q, p_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [15:0]      prod;
  logic             accept;

  function automatic logic [ACC_W-1:0] add_product(input logic [ACC_W-1:0] sum,
                                                   input logic [15:0]      p);
    return sum + ACC_W'(p);
  endfunction

  mult u_mult (.A(a_q), .B(b_q), .Out(prod));

  assign in_ready  = (state_q == ACC) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? acc_q : '0;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p_valid_d = 1'b0;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    in_cnt_d  = in_cnt_q;
    case (state_q)
      ACC, DRAIN: begin
        if (flush) begin
          // Drop the partial sum, the pending product and any pair offered this cycle
          acc_d     = '0;
          acc_cnt_d = '0;
          in_cnt_d  = '0;
          state_d   = ACC;
        end else begin
          if (p_valid_q) begin
            acc_d     = add_product(acc_q, prod);
            acc_cnt_d = acc_cnt_q + ONE;
          end
          if (state_q == DRAIN) begin
            state_d = DONE;
          end else if (accept) begin
            a_d       = A;
            b_d       = B;
            p_valid_d = 1'b1;
            in_cnt_d  = in_cnt_q + ONE;
            if (in_cnt_q == LAST) state_d = DRAIN;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d     = '0;
          acc_cnt_d = '0;
          in_cnt_d  = '0;
          state_d   = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      a_q       <= '0;
      b_q       <= '0;
      p_valid_q <= 1'b0;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      in_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_valid_q <= p_valid_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      in_cnt_q  <= in_cnt_d;
    end
  end
endmodule

// File: tb/tb_mult_dot_acc.sv
// Bench for mult_dot_acc: directed and randomized vectors against a plain-arithmetic
// dot-product model, on a LEN=4 instance and a LEN=256 instance.
module tb_mult_dot_acc;
  localparam int LEN    = 4;
  localparam int ACC_W  = 16 + $clog2(LEN);
  localparam int LEN2   = 256;
  localparam int ACC_W2 = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0]        a, b;
  logic [ACC_W-1:0]  out_data;
  logic              in_valid2, in_ready2, flush2, out_valid2, out_ready2;
  logic [7:0]        a2, b2;
  logic [ACC_W2-1:0] out_data2;

  int checks = 0;
  int errors = 0;
  int va[$];
  int vb[$];

  mult_dot_acc #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  mult_dot_acc #(.LEN(LEN2), .ACC_W(ACC_W2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .A(a2), .B(b2),
    .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
  );

  always #5 clk = ~clk;

  function automatic longint model_dot();
    longint s = 0;
    foreach (va[i]) s += longint'(va[i]) * longint'(vb[i]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int x, input int y);
    va.delete(); vb.delete();
    for (int i = 0; i < LEN; i++) begin va.push_back(x); vb.push_back(y); end
  endtask

  task automatic rand_vec();
    va.delete(); vb.delete();
    for (int i = 0; i < LEN; i++) begin
      va.push_back(int'($urandom_range(0, 255)));
      vb.push_back(int'($urandom_range(0, 255)));
    end
  endtask

  // Presents va/vb; returns just after the edge that accepts the last pair.
  task automatic send_pairs(input bit gaps);
    for (int i = 0; i < va.size(); i++) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 3));
        in_valid = 1'b0;
        for (int k = 0; k < g; k++) step();
      end
      in_valid = 1'b1;
      a = 8'(va[i]);
      b = 8'(vb[i]);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL send_ready[%0d]: in_ready=%b required 1", i, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // Called right after the last accept: one DRAIN cycle, then the result.
  task automatic expect_result(input longint exp, input string name);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: out_valid=%b required 0", name, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || longint'(out_data) !== exp) begin
      errors++;
      $display("FAIL %s: out_valid=%b out_data=%0d required 1/%0d", name, out_valid,
               out_data, exp);
    end
    if (out_ready) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
        errors++;
        $display("FAIL %s_release: out_valid=%b in_ready=%b out_data=%0d required 0/1/0",
                 name, out_valid, in_ready, out_data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; flush = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = 8'h0; b2 = 8'h0; flush2 = 1'b0; out_ready2 = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: in_ready=%b out_valid=%b required 0/0", i,
                 in_ready, out_valid);
      end
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || in_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b out_data=%0d in_ready2=%b required 1/0/0/1",
               in_ready, out_valid, out_data, in_ready2);
    end
    step();
  endtask

  task automatic test_basic();
    va = '{1, 2, 7, 200};
    vb = '{1, 3, 56, 100};
    send_pairs(1'b0);
    expect_result(64'd20399, "basic");
    for (int r = 0; r < 3; r++) begin
      rand_vec();
      send_pairs(1'b0);
      expect_result(model_dot(), $sformatf("random%0d", r));
    end
  endtask

  task automatic test_max();
    set_vec(255, 255);
    send_pairs(1'b0);
    expect_result(64'd260100, "max4");
    for (int i = 0; i < LEN2; i++) begin
      in_valid2 = 1'b1; a2 = 8'hFF; b2 = 8'hFF;
      step();
    end
    in_valid2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL max256_drain: out_valid=%b required 0", out_valid2);
    end
    step();
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 24'd16646400) begin
      errors++;
      $display("FAIL max256: out_valid=%b out_data=%0d required 1/16646400", out_valid2,
               out_data2);
    end
    step();
  endtask

  task automatic test_backpressure();
    longint exp;
    out_ready = 1'b0;
    rand_vec();
    exp = model_dot();
    send_pairs(1'b0);
    expect_result(exp, "bp_result");
    in_valid = 1'b1; a = 8'd1; b = 8'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || longint'(out_data) !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b out_data=%0d in_ready=%b required 1/%0d/0",
                 i, out_valid, out_data, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    set_vec(1, 1);
    send_pairs(1'b0);
    expect_result(64'd4, "bp_next");
  endtask

  task automatic test_flush();
    longint exp;
    va = '{100, 50};
    vb = '{100, 2};
    send_pairs(1'b0);
    flush = 1'b1; in_valid = 1'b1; a = 8'd9; b = 8'd9;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    set_vec(3, 3);
    send_pairs(1'b0);
    expect_result(64'd36, "flush_next");
    out_ready = 1'b0;
    rand_vec();
    exp = model_dot();
    send_pairs(1'b0);
    expect_result(exp, "flush_done_result");
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || longint'(out_data) !== exp) begin
        errors++;
        $display("FAIL flush_in_done[%0d]: out_valid=%b out_data=%0d required 1/%0d", i,
                 out_valid, out_data, exp);
      end
    end
    flush = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_release: out_valid=%b in_ready=%b required 0/1", out_valid,
               in_ready);
    end
  endtask

  task automatic test_bubbles_and_reset();
    for (int r = 0; r < 2; r++) begin
      rand_vec();
      send_pairs(1'b1);
      expect_result(model_dot(), $sformatf("bubbles%0d", r));
    end
    va = '{200, 150};
    vb = '{250, 99};
    send_pairs(1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL midreset_state: out_valid=%b in_ready=%b out_data=%0d required 0/1/0",
               out_valid, in_ready, out_data);
    end
    set_vec(2, 2);
    send_pairs(1'b0);
    expect_result(64'd16, "midreset_next");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_flush();
    test_bubbles_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
